// File: rtl/rom_download_ctrl.sv
// rom_download_ctrl
// Turns the data_io byte-download stream into byte-masked 16-bit writes on
// one toggle-handshake SDRAM port. Each ioctl byte strobe is queued in a
// small FIFO. The FIFO is replayed one request at a time. rom_loaded goes
// high once the download has ended and every queued byte has been acknowledged.
//
// Ports
//   clk_sys      system clock (rising edge)
//   reset        asynchronous active-high reset
//   ioctl_downl  download in progress
//   ioctl_wr     byte strobe (level; one byte per rising edge)
//   ioctl_addr   byte address
//   ioctl_dout   byte data
//   port_req     request toggle to SDRAM
//   port_ack     acknowledge toggle from SDRAM (copied from req on completion)
//   port_a       word address (ioctl_addr[AW:1])
//   port_ds      byte enables {hi,lo}
//   port_we      write enable
//   port_d       write data (byte replicated in both lanes)
//   busy         FIFO non-empty or a request is outstanding
//   overflow     sticky: a byte was dropped because the FIFO was full
//   rom_loaded   download finished and fully drained
module rom_download_ctrl #(
  parameter int AW         = 23,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_downl,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  output logic [15:0]   port_d,
  output logic          busy,
  output logic          overflow,
  output logic          rom_loaded
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = AW + 1 + 8;  // {addr[AW:0], byte}

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Upper byte-address bits beyond the SDRAM range are not stored.
  generate
    if (AW < 24) begin : g_addr_unused
      logic unused_addr_s;
      assign unused_addr_s = ^ioctl_addr[24:AW+1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                state_q, state_d;
  logic                  wr_last_q, wr_last_d;
  logic                  downl_last_q, downl_last_d;
  logic                  done_pend_q, done_pend_d;
  logic                  rom_loaded_q, rom_loaded_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic                  req_q, req_d;
  logic [AW-1:0]         a_q, a_d;
  logic [1:0]            ds_q, ds_d;
  logic                  we_q, we_d;
  logic [15:0]           d_q, d_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic                  push_s, push_ok_s, drop_s, pop_s, full_s;
  logic                  downl_rise_s, downl_fall_s;
  logic [EW-1:0]         head_s;
  logic [AW:0]           head_addr_s;
  logic [7:0]            head_byte_s;

  assign push_s       = ioctl_downl & ioctl_wr & ~wr_last_q;
  assign full_s       = (count_q == CNT_FULL);
  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign push_ok_s    = push_s & (~full_s | pop_s);
  assign drop_s       = push_s & full_s & ~pop_s;
  assign downl_rise_s = ioctl_downl & ~downl_last_q;
  assign downl_fall_s = ~ioctl_downl & downl_last_q;

  assign head_s       = mem_q[rd_ptr_q];
  assign head_addr_s  = head_s[EW-1:8];
  assign head_byte_s  = head_s[7:0];

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= {ioctl_addr[AW:0], ioctl_dout};
    end
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Request FSM: issue the head entry, then hold outputs until ack matches req.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    a_d     = a_q;
    ds_d    = ds_q;
    we_d    = we_q;
    d_d     = d_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != CNT_ZERO) begin
          a_d     = head_addr_s[AW:1];
          ds_d    = {head_addr_s[0], ~head_addr_s[0]};
          d_d     = {head_byte_s, head_byte_s};
          we_d    = 1'b1;
          req_d   = ~req_q;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (port_ack == req_q) begin
          pop_s   = 1'b1;
          we_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Download tracking: strobe/downl edge history, overflow, completion.
  always_comb begin
    wr_last_d    = ioctl_wr;
    downl_last_d = ioctl_downl;
    overflow_d   = overflow_q;
    done_pend_d  = done_pend_q;
    rom_loaded_d = rom_loaded_q;

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (done_pend_q && (count_q == CNT_ZERO) && (state_q == S_IDLE)) begin
      rom_loaded_d = 1'b1;
      done_pend_d  = 1'b0;
    end else begin
      rom_loaded_d = rom_loaded_q;
    end

    if (downl_fall_s) begin
      done_pend_d = 1'b1;
    end else begin
      done_pend_d = done_pend_d;
    end

    // A new download restarts tracking; this wins over a same-cycle drop.
    if (downl_rise_s) begin
      rom_loaded_d = 1'b0;
      overflow_d   = 1'b0;
      done_pend_d  = 1'b0;
    end else begin
      rom_loaded_d = rom_loaded_d;
    end

    busy_d = (count_d != CNT_ZERO) | (state_d == S_WAIT);
  end

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_last_q    <= 1'b0;
      downl_last_q <= 1'b0;
      done_pend_q  <= 1'b0;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      a_q          <= {AW{1'b0}};
      ds_q         <= 2'b00;
      we_q         <= 1'b0;
      d_q          <= 16'h0000;
      wr_ptr_q     <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q     <= {DEPTH_LOG2{1'b0}};
      count_q      <= CNT_ZERO;
    end else begin
      state_q      <= state_d;
      wr_last_q    <= wr_last_d;
      downl_last_q <= downl_last_d;
      done_pend_q  <= done_pend_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      req_q        <= req_d;
      a_q          <= a_d;
      ds_q         <= ds_d;
      we_q         <= we_d;
      d_q          <= d_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign port_req   = req_q;
  assign port_a     = a_q;
  assign port_ds    = ds_q;
  assign port_we    = we_q;
  assign port_d     = d_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed testbench for rom_download_ctrl with an SDRAM ack responder
// (configurable delay) and a request recorder.
module tb_rom_download_ctrl;

  localparam int AW = 23;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_downl;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_d;
  logic          busy;
  logic          overflow;
  logic          rom_loaded;

  int tests  = 0;
  int failed = 0;

  int ack_delay = 1;
  int ack_cnt   = 0;

  logic          req_prev = 1'b0;
  int            req_cnt  = 0;
  logic [63:0]   rec [1024];

  rom_download_ctrl #(.AW(AW), .DEPTH_LOG2(2)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_a      (port_a),
    .port_ds     (port_ds),
    .port_we     (port_we),
    .port_d      (port_d),
    .busy        (busy),
    .overflow    (overflow),
    .rom_loaded  (rom_loaded)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: copy req into ack ack_delay cycles after it changes.
  always @(negedge clk_sys) begin
    if (reset) begin
      port_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (port_req !== port_ack) begin
      if (ack_cnt + 1 >= ack_delay) begin
        port_ack <= port_req;
        ack_cnt  <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // Record {a, ds, d, we} at every request toggle.
  always @(negedge clk_sys) begin
    if (reset) begin
      req_prev <= 1'b0;
    end else if (port_req !== req_prev) begin
      req_prev     <= port_req;
      rec[req_cnt] <= {22'd0, port_a, port_ds, port_d, port_we};
      req_cnt      <= req_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic drain(input int base, input int n, input string tag);
    for (int k = 0; k < 3000; k++) begin
      if ((req_cnt - base) == n && busy == 1'b0) break;
      tick();
    end
    check({tag, "_reqs"}, 64'(req_cnt - base), 64'(n));
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_loaded(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (rom_loaded == 1'b1) break;
      tick();
    end
    check(tag, {63'd0, rom_loaded}, 64'd1);
  endtask

  function automatic logic [63:0] exp_rec(input logic [24:0] addr, input logic [7:0] data);
    logic [AW-1:0] a;
    logic [1:0]    ds;
    a  = addr[AW:1];
    ds = {addr[0], ~addr[0]};
    return {22'd0, a, ds, data, data, 1'b1};
  endfunction

  initial begin
    int            base;
    logic          b1, b2;
    logic [24:0]   ov_addr [5];
    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'd0;
    tick(); tick(); tick();

    // Reset state
    check("rst_req",  {63'd0, port_req},   64'd0);
    check("rst_a",    64'(port_a),         64'd0);
    check("rst_ds",   64'(port_ds),        64'd0);
    check("rst_we",   {63'd0, port_we},    64'd0);
    check("rst_d",    64'(port_d),         64'd0);
    check("rst_busy", {63'd0, busy},       64'd0);
    check("rst_ovf",  {63'd0, overflow},   64'd0);
    check("rst_rl",   {63'd0, rom_loaded}, 64'd0);
    reset = 1'b0;

    // Single byte at 0x000005, ack 3 cycles after req
    ack_delay   = 3;
    ioctl_downl = 1'b1;
    tick();
    base       = req_cnt;
    ioctl_addr = 25'h000005;
    ioctl_dout = 8'hA7;
    ioctl_wr   = 1'b1;
    tick();
    check("t1_req_e1",  {63'd0, port_req}, 64'd0);
    check("t1_busy_e1", {63'd0, busy},     64'd1);
    ioctl_wr = 1'b0;
    tick();
    check("t1_req_e2", {63'd0, port_req}, 64'd1);
    check("t1_a",      64'(port_a),       64'd2);
    check("t1_ds",     64'(port_ds),      64'd2);
    check("t1_d",      64'(port_d),       64'hA7A7);
    check("t1_we",     {63'd0, port_we},  64'd1);
    tick(); tick();
    check("t1_we_hold", {63'd0, port_we}, 64'd1);
    tick();
    check("t1_we_drop", {63'd0, port_we}, 64'd0);
    check("t1_busy0",   {63'd0, busy},    64'd0);
    ioctl_downl = 1'b0;
    tick();
    check("t1_rl_pend", {63'd0, rom_loaded}, 64'd0);
    tick();
    check("t1_rl", {63'd0, rom_loaded}, 64'd1);
    check("t1_nreq", 64'(req_cnt - base), 64'd1);

    // Strobe while no download is in progress is ignored
    base = req_cnt;
    strobe(25'h000010, 8'h55);
    tick();
    check("ign_busy", {63'd0, busy}, 64'd0);
    check("ign_reqs", 64'(req_cnt - base), 64'd0);

    // Overflow burst: 8 strobes 2 cycles apart, ack after 10 cycles
    ack_delay   = 10;
    ioctl_downl = 1'b1;
    tick();
    check("t2_rl_clear", {63'd0, rom_loaded}, 64'd0);
    base = req_cnt;
    for (int i = 0; i < 8; i++) begin
      strobe(25'h000100 + 25'(i), 8'h10 + 8'(i));
    end
    check("t2_ovf", {63'd0, overflow}, 64'd1);
    drain(base, 5, "t2");
    tick(); tick(); tick();
    check("t2_nreq_final", 64'(req_cnt - base), 64'd5);
    check("t2_ovf_sticky", {63'd0, overflow},   64'd1);
    ov_addr[0] = 25'h100; ov_addr[1] = 25'h101; ov_addr[2] = 25'h102;
    ov_addr[3] = 25'h103; ov_addr[4] = 25'h106;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_rec%0d", i), rec[base + i],
            exp_rec(ov_addr[i], 8'h10 + 8'(ov_addr[i][2:0])));
    end

    // downl falls with 3 entries pending
    ack_delay = 4;
    base      = req_cnt;
    for (int i = 0; i < 3; i++) begin
      strobe(25'h000200 + 25'(i), 8'hC0 + 8'(i));
    end
    ioctl_downl = 1'b0;
    b1 = busy;
    b2 = busy;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (rom_loaded == 1'b1) break;
      b2 = b1;
      b1 = busy;
    end
    check("t3_rl",       {63'd0, rom_loaded}, 64'd1);
    check("t3_nreq",     64'(req_cnt - base), 64'd3);
    check("t3_busy_m1",  {63'd0, b1},         64'd0);
    check("t3_busy_m2",  {63'd0, b2},         64'd1);
    check("t3_ovf_kept", {63'd0, overflow},   64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_rec%0d", i), rec[base + i],
            exp_rec(25'h000200 + 25'(i), 8'hC0 + 8'(i)));
    end

    // Second download: immediate ack, 256 bytes
    ack_delay   = 1;
    ioctl_downl = 1'b1;
    tick();
    check("t4_rl_clear",  {63'd0, rom_loaded}, 64'd0);
    check("t4_ovf_clear", {63'd0, overflow},   64'd0);
    base = req_cnt;
    for (int i = 0; i < 256; i++) begin
      strobe(25'(i), 8'(i) ^ 8'h5A);
    end
    drain(base, 256, "t4");
    for (int i = 0; i < 256; i++) begin
      check($sformatf("t4_rec%0d", i), rec[base + i], exp_rec(25'(i), 8'(i) ^ 8'h5A));
    end
    check("t4_ovf", {63'd0, overflow}, 64'd0);
    ioctl_downl = 1'b0;
    wait_loaded("t4_rl");

    // Async reset while a request is outstanding
    ack_delay   = 20;
    ioctl_downl = 1'b1;
    tick();
    strobe(25'h000033, 8'h99);
    check("t5_we_wait",   {63'd0, port_we}, 64'd1);
    check("t5_busy_wait", {63'd0, busy},    64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_req",  {63'd0, port_req},   64'd0);
    check("t5_a",    64'(port_a),         64'd0);
    check("t5_ds",   64'(port_ds),        64'd0);
    check("t5_we",   {63'd0, port_we},    64'd0);
    check("t5_d",    64'(port_d),         64'd0);
    check("t5_busy", {63'd0, busy},       64'd0);
    check("t5_ovf",  {63'd0, overflow},   64'd0);
    check("t5_rl",   {63'd0, rom_loaded}, 64'd0);
    tick(); tick();
    reset     = 1'b0;
    ack_delay = 2;
    base      = req_cnt;
    strobe(25'h000044, 8'h3C);
    drain(base, 1, "t5_after");
    check("t5_rec", rec[base], exp_rec(25'h000044, 8'h3C));
    ioctl_downl = 1'b0;
    wait_loaded("t5_rl_after");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
